// File: rtl/maindec_pipe.sv
// Main decoder for a five-stage ARMv8 subset pipeline. It decodes in ID and carries the
// controls through ID/EX, EX/MEM and MEM/WB. It also detects load-use hazards and keeps retire/bubble counters.
module maindec_pipe #(
    parameter int REGW   = 5,
    parameter int CNTW   = 32,
    parameter int EN_IMM = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [10:0]     Op,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rn,
    input  logic [REGW-1:0] id_rm,
    input  logic [REGW-1:0] id_rt,
    input  logic            flush,
    input  logic            hold,
    output logic            Reg2Loc,
    output logic            illegal,
    output logic            stall,
    output logic            ex_ALUSrc,
    output logic [1:0]      ex_ALUOp,
    output logic [REGW-1:0] ex_rd,
    output logic            mem_MemRead,
    output logic            mem_MemWrite,
    output logic            mem_Branch,
    output logic            wb_MemtoReg,
    output logic            wb_RegWrite,
    output logic [REGW-1:0] wb_rd,
    output logic [CNTW-1:0] retired,
    output logic [CNTW-1:0] bubbles
);

    localparam logic [10:0]     OP_LDUR = 11'b11111000010;
    localparam logic [10:0]     OP_STUR = 11'b11111000000;
    localparam logic [10:0]     OP_ADD  = 11'b10001011000;
    localparam logic [10:0]     OP_SUB  = 11'b11001011000;
    localparam logic [10:0]     OP_AND  = 11'b10001010000;
    localparam logic [10:0]     OP_ORR  = 11'b10101010000;
    localparam logic [REGW-1:0] XZR     = REGW'(31);
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    typedef struct packed {
        logic       reg2loc;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic            alu_src;
        logic [1:0]      alu_op;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            mem_to_reg;
        logic            reg_write;
        logic            valid;
        logic [REGW-1:0] rd;
    } idex_t;

    typedef struct packed {
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            mem_to_reg;
        logic            reg_write;
        logic            valid;
        logic [REGW-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic            mem_to_reg;
        logic            reg_write;
        logic            valid;
        logic [REGW-1:0] rd;
    } memwb_t;

    ctrl_t           dec_ctrl;
    ctrl_t           id_ctrl;
    logic            dec_hit;
    logic            dec_cbz;
    logic            hazard;
    logic [REGW-1:0] id_src2;
    logic            advance;

    idex_t           ex_q,  ex_d;
    exmem_t          mem_q, mem_d;
    memwb_t          wb_q,  wb_d;
    logic [CNTW-1:0] retired_q, retired_d;
    logic [CNTW-1:0] bubbles_q, bubbles_d;

    // Raw opcode match. id_valid is applied separately, so dec_hit alone means "Op is known".
    always_comb begin
        dec_ctrl = '0;
        dec_hit  = 1'b0;
        dec_cbz  = 1'b0;
        if (Op == OP_LDUR) begin
            dec_hit  = 1'b1;
            dec_ctrl = 9'b011110000;
        end else if (Op == OP_STUR) begin
            dec_hit  = 1'b1;
            dec_ctrl = 9'b110001000;
        end else if (Op[10:3] == 8'b10110100) begin
            dec_hit  = 1'b1;
            dec_cbz  = 1'b1;
            dec_ctrl = 9'b100000101;
        end else if (Op == OP_ADD || Op == OP_SUB || Op == OP_AND || Op == OP_ORR) begin
            dec_hit  = 1'b1;
            dec_ctrl = 9'b000100010;
        end else if ((EN_IMM != 0) &&
                     (Op[10:1] == 10'b1001000100 || Op[10:1] == 10'b1101000100)) begin
            dec_hit  = 1'b1;
            dec_ctrl = 9'b010100010;
        end
    end

    always_comb begin
        id_ctrl = (id_valid && dec_hit) ? dec_ctrl : '0;
        illegal = id_valid && !dec_hit;
        Reg2Loc = id_ctrl.reg2loc;
    end

    // CBZ reads only the register in the rt slot, so a match on rn must not stall it.
    always_comb begin
        id_src2 = dec_ctrl.reg2loc ? id_rt : id_rm;
        hazard  = ex_q.mem_read && (ex_q.rd != XZR) && id_valid && dec_hit &&
                  (((ex_q.rd == id_rn) && !dec_cbz) || (ex_q.rd == id_src2));
        stall   = hazard && !hold && !flush;
        advance = flush || !hold;
    end

    always_comb begin
        ex_d      = ex_q;
        mem_d     = mem_q;
        wb_d      = wb_q;
        retired_d = retired_q;
        bubbles_d = bubbles_q;

        if (advance) begin
            wb_d.mem_to_reg = mem_q.mem_to_reg;
            wb_d.reg_write  = mem_q.reg_write;
            wb_d.valid      = mem_q.valid;
            wb_d.rd         = mem_q.rd;
            if (wb_q.valid && retired_q != CNT_MAX) begin
                retired_d = retired_q + CNTW'(1);
            end
        end

        if (flush) begin
            ex_d  = '0;
            mem_d = '0;
        end else if (!hold) begin
            mem_d.mem_read   = ex_q.mem_read;
            mem_d.mem_write  = ex_q.mem_write;
            mem_d.branch     = ex_q.branch;
            mem_d.mem_to_reg = ex_q.mem_to_reg;
            mem_d.reg_write  = ex_q.reg_write;
            mem_d.valid      = ex_q.valid;
            mem_d.rd         = ex_q.rd;
            if (stall) begin
                ex_d = '0;
                if (bubbles_q != CNT_MAX) begin
                    bubbles_d = bubbles_q + CNTW'(1);
                end
            end else begin
                ex_d.alu_src    = id_ctrl.alu_src;
                ex_d.alu_op     = id_ctrl.alu_op;
                ex_d.mem_read   = id_ctrl.mem_read;
                ex_d.mem_write  = id_ctrl.mem_write;
                ex_d.branch     = id_ctrl.branch;
                ex_d.mem_to_reg = id_ctrl.mem_to_reg;
                ex_d.reg_write  = id_ctrl.reg_write;
                ex_d.valid      = id_valid;
                ex_d.rd         = id_valid ? id_rt : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            retired_q <= '0;
            bubbles_q <= '0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            retired_q <= retired_d;
            bubbles_q <= bubbles_d;
        end
    end

    always_comb begin
        ex_ALUSrc    = ex_q.alu_src;
        ex_ALUOp     = ex_q.alu_op;
        ex_rd        = ex_q.rd;
        mem_MemRead  = mem_q.mem_read;
        mem_MemWrite = mem_q.mem_write;
        mem_Branch   = mem_q.branch;
        wb_MemtoReg  = wb_q.mem_to_reg;
        wb_RegWrite  = wb_q.reg_write;
        wb_rd        = wb_q.rd;
        retired      = retired_q;
        bubbles      = bubbles_q;
    end

endmodule

// File: tb/tb_maindec_pipe.sv
// Scoreboard bench for maindec_pipe. A second instance (no immediates, 2-bit counters) shares
// the inputs and covers the illegal-immediate and counter-saturation cases.
module tb_maindec_pipe;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_SUBI = 11'b11010001001;
    localparam logic [10:0] OP_BAD  = 11'b11111111111;

    localparam logic [8:0] C_LDUR = 9'b011110000;
    localparam logic [8:0] C_STUR = 9'b110001000;
    localparam logic [8:0] C_CBZ  = 9'b100000101;
    localparam logic [8:0] C_RTYP = 9'b000100010;
    localparam logic [8:0] C_IMM  = 9'b010100010;
    localparam logic [8:0] C_NONE = 9'b000000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] Op;
    logic        id_valid, flush, hold;
    logic [4:0]  id_rn, id_rm, id_rt;

    logic        Reg2Loc, illegal, stall, ex_ALUSrc, mem_MemRead, mem_MemWrite, mem_Branch;
    logic        wb_MemtoReg, wb_RegWrite;
    logic [1:0]  ex_ALUOp;
    logic [4:0]  ex_rd, wb_rd;
    logic [31:0] retired, bubbles;

    logic        d0_Reg2Loc, d0_illegal, d0_stall, d0_ex_ALUSrc, d0_mem_MemRead, d0_mem_MemWrite;
    logic        d0_mem_Branch, d0_wb_MemtoReg, d0_wb_RegWrite;
    logic [1:0]  d0_ex_ALUOp;
    logic [4:0]  d0_ex_rd, d0_wb_rd;
    logic [1:0]  d0_retired, d0_bubbles;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         due;
        logic [7:0] v;
    } exp_t;
    exp_t exq[$];
    exp_t memq[$];
    exp_t wbq[$];

    always #5 clk = ~clk;

    maindec_pipe #(.REGW(5), .CNTW(32), .EN_IMM(1)) dut (
        .clk(clk), .reset(reset), .Op(Op), .id_valid(id_valid),
        .id_rn(id_rn), .id_rm(id_rm), .id_rt(id_rt), .flush(flush), .hold(hold),
        .Reg2Loc(Reg2Loc), .illegal(illegal), .stall(stall),
        .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .ex_rd(ex_rd),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_Branch(mem_Branch),
        .wb_MemtoReg(wb_MemtoReg), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd),
        .retired(retired), .bubbles(bubbles)
    );

    maindec_pipe #(.REGW(5), .CNTW(2), .EN_IMM(0)) dut0 (
        .clk(clk), .reset(reset), .Op(Op), .id_valid(id_valid),
        .id_rn(id_rn), .id_rm(id_rm), .id_rt(id_rt), .flush(flush), .hold(hold),
        .Reg2Loc(d0_Reg2Loc), .illegal(d0_illegal), .stall(d0_stall),
        .ex_ALUSrc(d0_ex_ALUSrc), .ex_ALUOp(d0_ex_ALUOp), .ex_rd(d0_ex_rd),
        .mem_MemRead(d0_mem_MemRead), .mem_MemWrite(d0_mem_MemWrite), .mem_Branch(d0_mem_Branch),
        .wb_MemtoReg(d0_wb_MemtoReg), .wb_RegWrite(d0_wb_RegWrite), .wb_rd(d0_wb_rd),
        .retired(d0_retired), .bubbles(d0_bubbles)
    );

    task automatic drive(input logic [10:0] op, input logic v, input logic [4:0] rn, rm, rt,
                         input logic fl, input logic hd);
        Op = op; id_valid = v; id_rn = rn; id_rm = rm; id_rt = rt; flush = fl; hold = hd;
    endtask

    // One clock; the pipeline-advance count stands still on held edges so due cycles stay aligned.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (!(hold && !flush)) cyc++;
        while (exq.size() != 0 && exq[0].due <= cyc) begin
            e = exq.pop_front();
            checks++;
            if (e.due != cyc || {ex_ALUSrc, ex_ALUOp, ex_rd} !== e.v) begin
                errors++;
                $display("FAIL sb_ex cyc=%0d actual=%h required=%h", cyc, {ex_ALUSrc, ex_ALUOp, ex_rd}, e.v);
            end
        end
        while (memq.size() != 0 && memq[0].due <= cyc) begin
            e = memq.pop_front();
            checks++;
            if (e.due != cyc || {5'b0, mem_MemRead, mem_MemWrite, mem_Branch} !== e.v) begin
                errors++;
                $display("FAIL sb_mem cyc=%0d actual=%b%b%b required=%h", cyc,
                         mem_MemRead, mem_MemWrite, mem_Branch, e.v);
            end
        end
        while (wbq.size() != 0 && wbq[0].due <= cyc) begin
            e = wbq.pop_front();
            checks++;
            if (e.due != cyc || {1'b0, wb_MemtoReg, wb_RegWrite, wb_rd} !== e.v) begin
                errors++;
                $display("FAIL sb_wb cyc=%0d actual=%h required=%h", cyc,
                         {1'b0, wb_MemtoReg, wb_RegWrite, wb_rd}, e.v);
            end
        end
    endtask

    task automatic nop(input int n);
        drive(11'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Issue one instruction that must not stall; c is its expected 9-bit control word.
    task automatic issue(input logic [10:0] op, input logic [4:0] rn, rm, rt, input logic [8:0] c);
        exp_t e;
        drive(op, 1'b1, rn, rm, rt, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL issue_stall op=%b actual=%b required=0", op, stall);
        end
        checks++;
        if (Reg2Loc !== c[8]) begin
            errors++; $display("FAIL issue_reg2loc op=%b actual=%b required=%b", op, Reg2Loc, c[8]);
        end
        e.due = cyc + 1; e.v = {c[7], c[1:0], rt};         exq.push_back(e);
        e.due = cyc + 2; e.v = {5'b0, c[4], c[3], c[2]};   memq.push_back(e);
        e.due = cyc + 3; e.v = {1'b0, c[6], c[5], rt};     wbq.push_back(e);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nop(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(11'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if ({ex_ALUSrc, ex_ALUOp, ex_rd, mem_MemRead, mem_MemWrite, mem_Branch,
             wb_MemtoReg, wb_RegWrite, wb_rd, stall, Reg2Loc, illegal} !== '0 ||
            retired !== 32'd0 || bubbles !== 32'd0) begin
            errors++;
            $display("FAIL reset_state actual ex=%h mem=%b%b%b wb_rd=%h ret=%0d bub=%0d required=0",
                     {ex_ALUSrc, ex_ALUOp, ex_rd}, mem_MemRead, mem_MemWrite, mem_Branch,
                     wb_rd, retired, bubbles);
        end
        reset = 1'b0;
    endtask

    task automatic test_ldur_latency();
        do_reset();
        issue(OP_LDUR, 5'd0, 5'd0, 5'd3, C_LDUR);
        nop(2);
        checks++;
        if (retired !== 32'd0) begin
            errors++; $display("FAIL ldur_retired_e3 actual=%0d required=0", retired);
        end
        nop(1);
        checks++;
        if (retired !== 32'd1) begin
            errors++; $display("FAIL ldur_retired_e4 actual=%0d required=1", retired);
        end
        nop(2);
        checks++;
        if (retired !== 32'd1 || wb_RegWrite !== 1'b0) begin
            errors++; $display("FAIL ldur_drain actual ret=%0d wbrw=%b required ret=1 wbrw=0", retired, wb_RegWrite);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        issue(OP_LDUR, 5'd0, 5'd0, 5'd3, C_LDUR);
        drive(OP_ADD, 1'b1, 5'd3, 5'd1, 5'd5, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL lu_stall actual=%b required=1", stall);
        end
        tick();
        checks++;
        if ({ex_ALUSrc, ex_ALUOp, ex_rd} !== 8'h00 || bubbles !== 32'd1) begin
            errors++; $display("FAIL lu_bubble actual ex=%h bub=%0d required ex=00 bub=1",
                               {ex_ALUSrc, ex_ALUOp, ex_rd}, bubbles);
        end
        issue(OP_ADD, 5'd3, 5'd1, 5'd5, C_RTYP);
        nop(5);
        checks++;
        if (retired !== 32'd2 || bubbles !== 32'd1) begin
            errors++; $display("FAIL lu_counts actual ret=%0d bub=%0d required ret=2 bub=1", retired, bubbles);
        end
    endtask

    task automatic test_hazard_variants();
        logic [10:0] hop[6];
        logic [4:0]  hrn[6], hrm[6], hrt[6];
        logic        hv[6], hfl[6], hhd[6], hexp[6];
        do_reset();
        issue(OP_LDUR, 5'd0, 5'd0, 5'd31, C_LDUR);
        issue(OP_ADD, 5'd31, 5'd2, 5'd6, C_RTYP);
        issue(OP_LDUR, 5'd0, 5'd0, 5'd8, C_LDUR);
        hop = '{OP_ADD, OP_ADD, OP_ADD, OP_STUR, OP_STUR, OP_CBZ};
        hrn = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd8};
        hrm = '{5'd8, 5'd8, 5'd8, 5'd0, 5'd8, 5'd0};
        hrt = '{5'd2, 5'd2, 5'd2, 5'd8, 5'd2, 5'd2};
        hv  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        hfl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        hhd = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        hexp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(hop[i], hv[i], hrn[i], hrm[i], hrt[i], hfl[i], hhd[i]);
            #1;
            checks++;
            if (stall !== hexp[i]) begin
                errors++; $display("FAIL hazard_case%0d actual=%b required=%b", i, stall, hexp[i]);
            end
        end
        drive(OP_CBZ, 1'b1, 5'd1, 5'd0, 5'd8, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL hazard_cbz_rt actual=%b required=1", stall);
        end
        drive(OP_BAD, 1'b1, 5'd8, 5'd8, 5'd8, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall !== 1'b0 || illegal !== 1'b1) begin
            errors++; $display("FAIL hazard_illegal actual stall=%b ill=%b required stall=0 ill=1", stall, illegal);
        end
        nop(5);
        checks++;
        if (bubbles !== 32'd0) begin
            errors++; $display("FAIL hazard_bubbles actual=%0d required=0", bubbles);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(OP_CBZ, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(OP_STUR, 1'b1, 5'd2, 5'd0, 5'd4, 1'b1, 1'b0);
        tick();
        checks++;
        if ({ex_ALUSrc, ex_ALUOp, ex_rd} !== 8'h00 || mem_Branch !== 1'b0 || mem_MemWrite !== 1'b0) begin
            errors++; $display("FAIL flush_early actual ex=%h br=%b mw=%b required 0", {ex_ALUSrc, ex_ALUOp, ex_rd},
                               mem_Branch, mem_MemWrite);
        end
        for (int i = 0; i < 4; i++) begin
            nop(1);
            checks++;
            if (mem_MemWrite !== 1'b0) begin
                errors++; $display("FAIL flush_early_mw i=%0d actual=%b required=0", i, mem_MemWrite);
            end
        end
        checks++;
        if (retired !== 32'd0) begin
            errors++; $display("FAIL flush_early_ret actual=%0d required=0", retired);
        end

        do_reset();
        drive(OP_CBZ, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(OP_STUR, 1'b1, 5'd2, 5'd0, 5'd4, 1'b0, 1'b0);
        tick();
        checks++;
        if (mem_Branch !== 1'b1 || ex_ALUSrc !== 1'b1) begin
            errors++; $display("FAIL flush_late_pre actual br=%b alusrc=%b required 1 1", mem_Branch, ex_ALUSrc);
        end
        drive(11'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        tick();
        checks++;
        if (mem_MemWrite !== 1'b0 || mem_Branch !== 1'b0 || ex_ALUSrc !== 1'b0) begin
            errors++; $display("FAIL flush_late_post actual mw=%b br=%b as=%b required 0", mem_MemWrite, mem_Branch, ex_ALUSrc);
        end
        nop(3);
        checks++;
        if (retired !== 32'd1 || mem_MemWrite !== 1'b0) begin
            errors++; $display("FAIL flush_late_ret actual ret=%0d mw=%b required ret=1 mw=0", retired, mem_MemWrite);
        end
    endtask

    task automatic test_hold();
        do_reset();
        issue(OP_ADD, 5'd1, 5'd2, 5'd9, C_RTYP);
        issue(OP_LDUR, 5'd0, 5'd0, 5'd3, C_LDUR);
        issue(OP_LDUR, 5'd0, 5'd0, 5'd7, C_LDUR);
        drive(OP_ADD, 1'b1, 5'd7, 5'd0, 5'd10, 1'b0, 1'b1);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL hold_stall actual=%b required=0", stall);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (mem_MemRead !== 1'b1 || wb_RegWrite !== 1'b1 || wb_rd !== 5'd9 ||
                retired !== 32'd0 || bubbles !== 32'd0) begin
                errors++; $display("FAIL hold_freeze i=%0d actual mr=%b wbrw=%b wbrd=%0d ret=%0d bub=%0d required 1 1 9 0 0",
                                   i, mem_MemRead, wb_RegWrite, wb_rd, retired, bubbles);
            end
        end
        drive(OP_ADD, 1'b1, 5'd7, 5'd0, 5'd10, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL hold_release_stall actual=%b required=1", stall);
        end
        tick();
        checks++;
        if (bubbles !== 32'd1 || retired !== 32'd1) begin
            errors++; $display("FAIL hold_release_counts actual bub=%0d ret=%0d required 1 1", bubbles, retired);
        end
        issue(OP_ADD, 5'd7, 5'd0, 5'd10, C_RTYP);
        nop(5);
        checks++;
        if (retired !== 32'd4) begin
            errors++; $display("FAIL hold_retired actual=%0d required=4", retired);
        end
    endtask

    task automatic test_illegal_imm();
        do_reset();
        drive(OP_ADDI, 1'b1, 5'd1, 5'd0, 5'd12, 1'b0, 1'b0);
        #1;
        checks++;
        if (illegal !== 1'b0 || d0_illegal !== 1'b1 || d0_Reg2Loc !== 1'b0) begin
            errors++; $display("FAIL imm_decode actual ill=%b d0ill=%b d0r2l=%b required 0 1 0", illegal, d0_illegal, d0_Reg2Loc);
        end
        issue(OP_ADDI, 5'd1, 5'd0, 5'd12, C_IMM);
        checks++;
        if ({d0_ex_ALUSrc, d0_ex_ALUOp} !== 3'b000) begin
            errors++; $display("FAIL imm_d0_ctrl actual=%b required=000", {d0_ex_ALUSrc, d0_ex_ALUOp});
        end
        issue(OP_SUBI, 5'd2, 5'd0, 5'd13, C_IMM);
        drive(OP_BAD, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if (illegal !== 1'b1) begin
            errors++; $display("FAIL illegal_bad actual=%b required=1", illegal);
        end
        issue(OP_BAD, 5'd0, 5'd0, 5'd0, C_NONE);
        drive(OP_BAD, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if (illegal !== 1'b0) begin
            errors++; $display("FAIL illegal_novalid actual=%b required=0", illegal);
        end
        nop(5);
        checks++;
        if (retired !== 32'd3 || d0_retired !== 2'd3) begin
            errors++; $display("FAIL illegal_retired actual ret=%0d d0=%0d required 3 3", retired, d0_retired);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] bop[7];
        logic [8:0]  bc[7];
        bop = '{OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_STUR, OP_CBZ, OP_LDUR};
        bc  = '{C_RTYP, C_RTYP, C_RTYP, C_RTYP, C_STUR, C_CBZ, C_LDUR};
        do_reset();
        for (int i = 0; i < 7; i++) issue(bop[i], 5'(i), 5'(i + 10), 5'(i + 1), bc[i]);
        nop(5);
        checks++;
        if (retired !== 32'd7 || d0_retired !== 2'd3) begin
            errors++; $display("FAIL b2b_retired actual ret=%0d d0=%0d required 7 3", retired, d0_retired);
        end
    endtask

    task automatic test_reset_midop();
        drive(OP_LDUR, 1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (ex_ALUSrc !== 1'b0 || ex_rd !== 5'd0 || retired !== 32'd0 || d0_retired !== 2'd0) begin
            errors++; $display("FAIL reset_async actual as=%b rd=%0d ret=%0d d0=%0d required 0", ex_ALUSrc, ex_rd, retired, d0_retired);
        end
        nop(1);
        reset = 1'b0;
        issue(OP_ADD, 5'd1, 5'd2, 5'd14, C_RTYP);
        nop(4);
        checks++;
        if (retired !== 32'd1 || mem_MemRead !== 1'b0) begin
            errors++; $display("FAIL reset_release actual ret=%0d mr=%b required 1 0", retired, mem_MemRead);
        end
    endtask

    initial begin
        test_reset();
        test_ldur_latency();
        test_load_use();
        test_hazard_variants();
        test_flush();
        test_hold();
        test_illegal_imm();
        test_back_to_back();
        test_reset_midop();
        checks++;
        if (exq.size() != 0 || memq.size() != 0 || wbq.size() != 0) begin
            errors++; $display("FAIL sb_leftover actual=%0d/%0d/%0d required=0", exq.size(), memq.size(), wbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/maindec_pipe.md
MAINDEC_PIPE -- requirements
Module: maindec_pipe

Interface
REQ-001 Parameter REGW, default 5, register-index width.
REQ-002 Parameter CNTW, default 32, performance-counter width.
REQ-003 Parameter EN_IMM, default 1, enables ADDI/SUBI decode when 1.
REQ-004 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Port Op  in  11  opcode field Instr[31:21] of the instruction in ID.
REQ-007 Port id_valid  in  1  ID holds a real instruction.
REQ-008 Port id_rn / id_rm / id_rt  in  REGW each  Instr[9:5] / Instr[20:16] / Instr[4:0].
REQ-009 Port flush  in  1  branch taken; squash ID/EX and EX/MEM.
REQ-010 Port hold  in  1  global freeze (memory wait).
REQ-011 Port Reg2Loc, illegal  out  1 each  combinational ID decode; illegal = id_valid and Op unmatched.
REQ-012 Port stall  out  1  load-use hazard; PC and IF/ID must freeze.
REQ-013 Port ex_ALUSrc  out  1, ex_ALUOp  out  2, ex_rd  out  REGW  ID/EX stage.
REQ-014 Port mem_MemRead, mem_MemWrite, mem_Branch  out  1 each  EX/MEM stage.
REQ-015 Port wb_MemtoReg, wb_RegWrite  out  1 each, wb_rd  out  REGW  MEM/WB stage.
REQ-016 Port retired, bubbles  out  CNTW each  performance counters.

Function
REQ-017 Decode {Reg2Loc,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp}: LDUR 11111000010 -> 011110000; STUR 11111000000 -> 110001000; CBZ 10110100xxx -> 100000101; ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> 000100010.
REQ-018 With EN_IMM=1: ADDI 1001000100x, SUBI 1101000100x -> 010100010; with EN_IMM=0 these are illegal.
REQ-019 Unmatched Op or id_valid=0 -> all nine control bits 0.
REQ-020 Three control registers ID/EX, EX/MEM, MEM/WB, each with a valid bit and rd; latency Op -> ex_* 1 cycle, mem_* 2, wb_* 3.
REQ-021 Load-use hazard: ex_MemRead=1, ex_rd != 31, id_valid=1, ID decode legal, and (ex_rd==id_rn with ID not CBZ, or ex_rd==(Reg2Loc ? id_rt : id_rm)).
REQ-022 stall is combinational, equals the hazard term, and is forced to 0 while hold=1 or flush=1.
REQ-023 On stall: ID/EX loads a bubble (all controls 0, valid 0, rd 0); EX/MEM and MEM/WB advance normally.
REQ-024 On flush: ID/EX and EX/MEM load bubbles; MEM/WB advances normally.
REQ-025 On hold (no flush): all three registers and both counters keep their values.
REQ-026 Priority: reset > flush > hold > stall > normal advance.
REQ-027 retired increments by 1 each non-hold cycle in which MEM/WB valid=1; saturates at 2^CNTW-1.
REQ-028 bubbles increments by 1 each cycle stall=1; saturates at 2^CNTW-1.
REQ-029 Illegal instructions propagate as valid with all controls 0 and are counted by retired.

Reset
REQ-030 reset=1 asynchronously clears all stage registers, valid bits, rd fields, retired and bubbles to 0; all registered outputs read 0 within the same cycle.
REQ-031 Reset deasserting mid-operation discards all in-flight instructions; the first legal Op after release appears on ex_* one edge later.

Verification
REQ-032 Op=11111000010, id_rt=3, id_valid=1 for one cycle -> ex_ALUSrc=1 and ex_rd=3 at edge 1; mem_MemRead=1 at edge 2; wb_MemtoReg=1, wb_RegWrite=1, wb_rd=3 at edge 3; retired=1 after edge 4.
REQ-033 LDUR X3, then ADD (Op=10001011000, id_rn=3) -> stall=1 for one cycle; bubble in ID/EX; bubbles=1; ADD reaches ex_ALUOp=10 one cycle late.
REQ-034 LDUR X31, then ADD id_rn=31 -> stall=0, bubbles stays 0.
REQ-035 CBZ (Op=10110100101) then STUR, flush=1 at the edge the STUR enters ID/EX -> mem_MemWrite never 1; mem_Branch from CBZ unaffected if CBZ is already in MEM/WB.
REQ-036 hold=1 for 3 cycles with LDUR in EX/MEM -> mem_MemRead stays 1, retired and bubbles unchanged; hold=1 plus hazard -> stall=0.
REQ-037 EN_IMM=0, Op=10010001000 -> illegal=1, all controls 0; EN_IMM=1 -> 010100010.
